// File: rtl/uart_tx_packetizer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : uart_tx_packetizer
// Purpose  : Serializes a W_BUS-bit payload as N_WORDS back-to-back UART
//            words (start bit, LSB-first data, trailing ones).
// Options  : UART_TX_PARITY_EN - first trailing bit carries even parity.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module uart_tx_packetizer #(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD    = 8,
  parameter int PACKET_SIZE_TX   = 13,
  parameter int W_BUS            = 40
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [W_BUS-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             tx,
  output logic             busy
);

  localparam int N_WORDS = W_BUS / BITS_PER_WORD;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int W_CC = $clog2(CLOCKS_PER_PULSE);
  localparam int W_BC = $clog2(PACKET_SIZE_TX);
  localparam int W_WC = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  localparam logic [W_CC-1:0] CC_LAST = W_CC'(CLOCKS_PER_PULSE - 1);
  localparam logic [W_BC-1:0] BC_LAST = W_BC'(PACKET_SIZE_TX - 1);
  localparam logic [W_BC-1:0] BC_BPW  = W_BC'(BITS_PER_WORD);
  localparam logic [W_WC-1:0] WC_LAST = W_WC'(N_WORDS - 1);

  // Reject parameter sets that cannot form a legal frame.
  generate
    if ((W_BUS % BITS_PER_WORD) != 0) begin : g_chk_width
      $error("W_BUS must be a multiple of BITS_PER_WORD");
    end
    if (PACKET_SIZE_TX < BITS_PER_WORD + 2 + PAR_BITS) begin : g_chk_packet
      $error("PACKET_SIZE_TX too small for start, data and stop bits");
    end
    if (CLOCKS_PER_PULSE < 2) begin : g_chk_cpp
      $error("CLOCKS_PER_PULSE must be at least 2");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [W_CC-1:0]   cc_q, cc_d;      // clocks within the current bit period
  logic [W_BC-1:0]   bc_q, bc_d;      // bit period within the current word
  logic [W_WC-1:0]   wc_q, wc_d;      // word index within the payload
  logic [W_BUS-1:0]  data_q, data_d;  // captured payload, current word in LSBs
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  // Line level for a given bit period of the word currently in the LSBs.
  function automatic logic bit_value(input logic [W_BC-1:0]          bc,
                                     input logic [BITS_PER_WORD-1:0] w);
    logic                     v;
    logic [BITS_PER_WORD-1:0] sh;
    v  = 1'b1;
    sh = w >> (bc - W_BC'(1));
    if (bc == '0) begin
      v = 1'b0;
    end else if (bc <= BC_BPW) begin
      v = sh[0];
    end
`ifdef UART_TX_PARITY_EN
    else if (bc == BC_BPW + W_BC'(1)) begin
      v = ^w;
    end
`endif
    return v;
  endfunction

  // State, counters, payload and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cc_q    <= '0;
      bc_q    <= '0;
      wc_q    <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cc_q    <= cc_d;
      bc_q    <= bc_d;
      wc_q    <= wc_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: accept in IDLE, walk clock/bit/word counters in SEND.
  always_comb begin
    state_d = state_q;
    cc_d    = cc_q;
    bc_d    = bc_q;
    wc_d    = wc_q;
    data_d  = data_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (s_valid && ready_q) begin
          state_d = ST_SEND;
          data_d  = s_data;
          cc_d    = '0;
          bc_d    = '0;
          wc_d    = '0;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_SEND: begin
        ready_d = 1'b0;
        busy_d  = 1'b1;
        if (cc_q == CC_LAST) begin
          cc_d = '0;
          if (bc_q == BC_LAST) begin
            bc_d = '0;
            if (wc_q == WC_LAST) begin
              state_d = ST_IDLE;
              wc_d    = '0;
              tx_d    = 1'b1;
              ready_d = 1'b1;
              busy_d  = 1'b0;
            end else begin
              // Next word moves into the LSBs and starts with its start bit.
              wc_d   = wc_q + W_WC'(1);
              data_d = data_q >> BITS_PER_WORD;
              tx_d   = 1'b0;
            end
          end else begin
            bc_d = bc_q + W_BC'(1);
            tx_d = bit_value(bc_d, data_q[BITS_PER_WORD-1:0]);
          end
        end else begin
          cc_d = cc_q + W_CC'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign tx      = tx_q;
  assign s_ready = ready_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_packetizer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_uart_tx_packetizer
// Purpose  : Self-checking bench for uart_tx_packetizer: cycle model of the
//            serial line, a UART decoder and directed literal expectations.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_uart_tx_packetizer;

  localparam int CPP = 4;
  localparam int BPW = 8;
  localparam int PS  = 13;
  localparam int WB  = 40;
  localparam int NW  = WB / BPW;
  localparam int XFER = NW * PS * CPP;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic [WB-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          tx;
  logic          busy;

  int tests = 0;
  int failed = 0;

  uart_tx_packetizer #(
    .CLOCKS_PER_PULSE(CPP),
    .BITS_PER_WORD   (BPW),
    .PACKET_SIZE_TX  (PS),
    .W_BUS           (WB)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .s_data (s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .tx     (tx),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: whole-transfer line waveform --------
  logic          m_tx = 1'b1;
  logic          m_ready = 1'b0;
  logic          m_busy = 1'b0;
  logic          m_q[$];
  logic [WB-1:0] sent_q[$];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      if (m_busy && sent_q.size() > 0) void'(sent_q.pop_back());
      m_q.delete();
      m_tx = 1'b1;
      m_ready = 1'b0;
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (m_q.size() > 0) begin
        m_tx = m_q.pop_front();
      end else begin
        m_tx = 1'b1;
        m_ready = 1'b1;
        m_busy = 1'b0;
      end
    end else if (s_valid && m_ready) begin
      for (int w = 0; w < NW; w++) begin
        logic [BPW-1:0] byt;
        byt = s_data[w*BPW +: BPW];
        for (int b = 0; b < PS; b++) begin
          logic v;
          if (b == 0)                   v = 1'b0;
          else if (b <= BPW)            v = byt[b-1];
          else if (PAR && b == BPW + 1) v = ^byt;
          else                          v = 1'b1;
          for (int c = 0; c < CPP; c++) m_q.push_back(v);
        end
      end
      sent_q.push_back(s_data);
      m_tx = m_q.pop_front();
      m_ready = 1'b0;
      m_busy = 1'b1;
    end else begin
      m_tx = 1'b1;
      m_ready = 1'b1;
    end
  end

  // Every-cycle comparison of the DUT outputs against the model.
  always @(negedge clk) begin
    tests++;
    if (tx !== m_tx || busy !== m_busy || s_ready !== m_ready) begin
      failed++;
      $display("FAIL cycle_model: got tx=%b busy=%b rdy=%b expected tx=%b busy=%b rdy=%b at %0t",
               tx, busy, s_ready, m_tx, m_busy, m_ready, $time);
    end
  end

  // ---------------- UART decoder: mid-bit sampling, payload reassembly ------
  bit             mon_active = 1'b0;
  int             mon_cnt = 0;
  bit             mon_ferr = 1'b0;
  logic [BPW-1:0] mon_byte = '0;
  logic [BPW-1:0] grp[$];
  int             frame_errs = 0;
  int             groups_done = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      mon_active = 1'b0;
      grp.delete();
    end else if (!mon_active) begin
      if (tx == 1'b0) begin
        mon_active = 1'b1;
        mon_cnt = 0;
        mon_ferr = 1'b0;
        mon_byte = '0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % CPP == CPP / 2) begin
        int k;
        k = mon_cnt / CPP;
        if (k == 0) begin
          if (tx !== 1'b0) mon_ferr = 1'b1;
        end else if (k <= BPW) begin
          mon_byte[k-1] = tx;
        end else if (PAR && k == BPW + 1) begin
          if (tx !== ^mon_byte) mon_ferr = 1'b1;
        end else if (tx !== 1'b1) begin
          mon_ferr = 1'b1;
        end
        if (k == PS - 1) begin
          mon_active = 1'b0;
          tests++;
          if (mon_ferr) begin
            failed++;
            frame_errs++;
            $display("FAIL framing: byte %0h has a bad frame at %0t", mon_byte, $time);
          end
          grp.push_back(mon_byte);
          if (grp.size() == NW) begin
            logic [WB-1:0] got;
            logic [WB-1:0] exp;
            for (int i = 0; i < NW; i++) got[i*BPW +: BPW] = grp[i];
            grp.delete();
            exp = (sent_q.size() > 0) ? sent_q.pop_front() : 'x;
            groups_done++;
            check("uart_payload", 64'(got), 64'(exp));
          end
        end
      end
    end
  end

  // ---------------- directed stimulus -------------------------------------
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (s_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (s_ready !== 1'b1) check({name, "_timeout"}, 64'(s_ready), 64'd1);
  endtask

  task automatic send(input logic [WB-1:0] p);
    wait_ready("send");
    s_data = p;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  logic a5_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int n;
    int lows;
    logic par0, par1;

    // Reset state
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_ready", 64'(s_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    #2 rstn = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 64'(s_ready), 64'd1);

    // Single A5 payload: start one cycle after s_valid, LSB-first, 260-cycle transfer
    s_data = 40'h00_00_00_00_A5;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    s_data = 40'hFF_FF_FF_FF_FF;
    check("t1_start_low", 64'(tx), 64'd0);
    check("t1_busy", 64'(busy), 64'd1);
    for (n = 1; n < XFER; n++) begin
      @(negedge clk);
      if (n % CPP == CPP / 2) begin
        int k, w, b;
        k = n / CPP;
        w = k / PS;
        b = k % PS;
        if (w == 0 && b >= 1 && b <= 8) check("t1_data", 64'(tx), 64'(a5_bits[b-1]));
        else if (w == 0 && b >= 9)      check("t1_trail", 64'(tx), 64'd1);
        else if (w >= 1 && b >= 1 && b <= 8) check("t1_zero_word", 64'(tx), 64'd0);
      end
    end
    check("t1_ready_low_last", 64'(s_ready), 64'd0);
    @(negedge clk);
    check("t1_ready_260", 64'(s_ready), 64'd1);
    check("t1_idle_tx", 64'(tx), 64'd1);

    // Back-to-back with s_valid held high
    s_data = 40'h12_34_56_78_9A;
    s_valid = 1'b1;
    @(negedge clk);
    s_data = 40'hC3_5A_0F_F0_81;
    n = 0;
    while (s_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("t2_first_len", 64'(n), 64'(XFER));
    @(negedge clk);
    check("t2_second_start", 64'(tx), 64'd0);
    check("t2_second_busy", 64'(busy), 64'd1);
    s_valid = 1'b0;
    wait_ready("t2");

    // s_data and s_valid churn during SEND
    send(40'hDE_AD_BE_EF_42);
    for (int i = 0; i < 200; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data = 40'({$urandom(), $urandom()});
      @(negedge clk);
      check("t3_ready_low", 64'(s_ready), 64'd0);
    end
    s_valid = 1'b0;
    wait_ready("t3");

    // Reset 100 cycles into a transfer
    send(40'h55_AA_33_CC_01);
    repeat (99) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("t4_async_tx", 64'(tx), 64'd1);
    check("t4_async_busy", 64'(busy), 64'd0);
    check("t4_async_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    #2 rstn = 1'b1;
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx == 1'b0) lows++;
    end
    check("t4_no_resume", 64'(lows), 64'd0);
    check("t4_ready", 64'(s_ready), 64'd1);

    // Parity slot: word0 = 0x07, word1 = 0x03
    send(40'h00_00_00_03_07);
    par0 = 1'bx;
    par1 = 1'bx;
    for (n = 1; n < XFER; n++) begin
      @(negedge clk);
      if (n == 9 * CPP + CPP / 2)           par0 = tx;
      if (n == (PS + 9) * CPP + CPP / 2)    par1 = tx;
      if (n == 10 * CPP + CPP / 2 || n == 11 * CPP + CPP / 2 || n == 12 * CPP + CPP / 2)
        check("t5_trail_ones", 64'(tx), 64'd1);
    end
`ifdef UART_TX_PARITY_EN
    check("t5_parity_07", 64'(par0), 64'd1);
    check("t5_parity_03", 64'(par1), 64'd0);
`else
    check("t5_trail_07", 64'(par0), 64'd1);
    check("t5_trail_03", 64'(par1), 64'd1);
`endif
    wait_ready("t5");

    // Ten random payloads through the decoder
    for (int i = 0; i < 10; i++) send(40'({$urandom(), $urandom()}));
    wait_ready("t6");
    repeat (5) @(negedge clk);
    check("t6_groups", 64'(groups_done), 64'd15);
    check("t6_pending", 64'(sent_q.size()), 64'd0);
    check("t6_frame_errs", 64'(frame_errs), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #2000000;
    failed++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
